command_engine: RTL
===================

// Module: command_engine
// PURPOSE
//   Parametrised successor to the host command processor. Receives fixed-length byte commands from the
//   USB bridge on an AXI-stream slave, decodes the opcode and acts on it. Actions are clock switch,
//   version read, multi-chip SPI transfer, register file access and length-bounded sample-FIFO readout.
//   Responses go out as 32-bit AXI-stream beats. Sits between the FT600/FT232H top and the ADC/SPI/FIFO blocks.
// PARAMETERS
//   CMD_BYTES   8      command length in bytes (>=8); byte0 opcode, byte1 index, bytes4..7 LE argument
//   N_SPI_CS    4      number of SPI chip selects (1..8)
//   N_REGS      8      number of 32-bit config registers (1..16)
//   FIFO_W      32     sample FIFO read width; low 32 bits are sent
//   USED_W      11     width of FIFO used-word count
//   VERSION     32'd5  value returned by opcode 2
//   SPI_TMO     4095   SPI wait timeout in clk cycles (only with CMDENG_SPI_TIMEOUT_EN)
// PORTS
//   clk           in   1              system clock
//   rstn          in   1              asynchronous active-low reset
//   i_tready      out  1              command byte accept; high only in RX
//   i_tvalid      in   1              command byte valid
//   i_tdata       in   8              command byte
//   o_tready      in   1              response sink ready
//   o_tvalid      out  1              response beat valid
//   o_tdata       out  32             response word
//   o_tkeep       out  4              byte enables for the beat
//   o_tlast       out  1              final beat of a response
//   clkswitch     out  1              PLL input clock select
//   spitx         out  8              SPI byte to send
//   spitxdv       out  1              one-cycle SPI send strobe
//   spitxready    in   1              SPI master idle
//   spirx         in   8              SPI byte received
//   spirxdv       in   1              SPI receive strobe
//   spics_n       out  N_SPI_CS       active-low chip selects
//   fifo_rd       out  1              one-cycle read-acknowledge to show-ahead FIFO
//   fifo_rdata    in   FIFO_W         FIFO head word
//   fifo_rdused   in   USED_W         FIFO words available
//   cfg_regs      out  32*N_REGS      flat register file, reg k at [32k+31:32k]
// BEHAVIOUR
//   Reset: state=RX, all outputs 0 except spics_n all-ones; cfg_regs=0; counters 0. Reset mid-command
//     discards the partial command and raises all chip selects.
//   States: RX -> DECODE -> {RESP | SPI_LD/SPI_GO/SPI_WAIT | RD_FETCH/RD_SEND} -> RX.
//   RX: one byte stored per i_tvalid&i_tready cycle; after byte CMD_BYTES-1 -> DECODE (next cycle).
//   Handshake: o_tvalid, once high, holds o_tdata/o_tkeep/o_tlast stable until o_tready.
//     A beat is transferred on o_tvalid&o_tready.
//   Opcodes (unknown or out-of-range index -> RESP with 32'hBAD0_00<opcode>):
//     0 readout: len = arg bytes; len==0 -> RX with no beat. RD_FETCH waits for fifo_rdused>=1.
//       It then pulses fifo_rd, latches fifo_rdata[31:0] and raises o_tvalid -> RD_SEND.
//       On transfer, len -= min(len,4). o_tkeep = 1111/0111/0011/0001 for remaining >=4/3/2/1.
//       o_tlast is set when remaining <= 4; after the last beat -> RX, else -> RD_FETCH.
//     1 toggle clkswitch; reply = new value, single beat, tkeep 1111, tlast 1.
//     2 reply VERSION.
//     3 SPI: cs = byte1 (<N_SPI_CS). Drive spics_n[cs] low and send bytes 2,3,4 in order.
//       Per byte: wait spitxready, strobe spitxdv one cycle. After the third byte, wait spirxdv.
//       Raise cs and reply {24'd0, spirx}.
//     4 write cfg reg byte1 <= arg; reply written value.
//     5 read cfg reg byte1; reply value.
//   Single-beat replies: 1-cycle DECODE, then o_tvalid next cycle; back to RX the cycle after transfer.
//   i_tvalid is ignored outside RX (back-pressure via i_tready=0).
// CONFIGURATION
//   CMDENG_SPI_TIMEOUT_EN defined: a counter runs during SPI_WAIT/spitxready waits.
//     At SPI_TMO cycles it raises cs and replies 32'hBAD0_0E03.
//   Undefined: SPI waits are unbounded (no counter synthesised).
// STRUCTURE
//   Package cmdeng_pkg: opcode localparams, state enum encoding, error word constants, tkeep function.
//   Sub-module cmdeng_spi_seq: 3-byte SPI sequencer (start, cs index, bytes, done, rx byte, timeout).
// TESTING
//   Op 2 -> one beat 32'h0000_0005, tkeep 1111, tlast 1; i_tready low until beat taken.
//   Op 0, len=10, FIFO holds 1,2,3: beats 1,2,3. tkeep 1111,1111,0011; tlast only on the third;
//     3 fifo_rd pulses. Also hold o_tready low 5 cycles: data stable.
//   Op 0, len=8, FIFO empty 20 cycles then 2 words: no o_tvalid while empty, then 2 beats.
//   Op 3, byte1=2, bytes AB CD EF, spirx=5A: spics_n=1011 during transfer; 3 spitxdv pulses;
//     reply 32'h0000_005A; spics_n back to 1111.
//   Op 4 reg3=12345678, op 5 reg3 -> 12345678; op 5 reg 20 -> 32'hBAD0_0005; op 9 -> 32'hBAD0_0009.
//   rstn low during RD_SEND: o_tvalid 0 immediately. Next command decodes from byte0 correctly.
//     With CMDENG_SPI_TIMEOUT_EN and spirxdv never asserted -> 32'hBAD0_0E03 after SPI_TMO cycles.

Source files
------------

// File: rtl/cmdeng_pkg.sv
// Shared opcodes, state encodings, error words and the readout byte-enable helper
// for command_engine and its SPI sequencer.
package cmdeng_pkg;

    localparam logic [7:0] OP_READOUT = 8'd0;
    localparam logic [7:0] OP_CLKSW   = 8'd1;
    localparam logic [7:0] OP_VERSION = 8'd2;
    localparam logic [7:0] OP_SPI     = 8'd3;
    localparam logic [7:0] OP_WRREG   = 8'd4;
    localparam logic [7:0] OP_RDREG   = 8'd5;

    localparam logic [31:0] ERR_BASE    = 32'hBAD0_0000;
    localparam logic [31:0] ERR_SPI_TMO = 32'hBAD0_0E03;

    typedef enum logic [2:0] {
        ST_RX,
        ST_DECODE,
        ST_RESP,
        ST_SPI,
        ST_RD_FETCH,
        ST_RD_SEND
    } state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_LD,
        SPI_GO,
        SPI_WAIT
    } spi_state_t;

    // Byte enables for a readout beat given the bytes still owed to the host.
    function automatic logic [3:0] tkeep_for(input logic [31:0] remaining);
        if (remaining >= 32'd4)      return 4'b1111;
        else if (remaining == 32'd3) return 4'b0111;
        else if (remaining == 32'd2) return 4'b0011;
        else                         return 4'b0001;
    endfunction

endpackage

// File: rtl/cmdeng_spi_seq.sv
// Three-byte SPI sequencer: selects one chip, sends three bytes, waits for the final receive strobe.
// Optional bounded waits with CMDENG_SPI_TIMEOUT_EN.
module cmdeng_spi_seq
    import cmdeng_pkg::*;
#(
    parameter int N_SPI_CS = 4,
    parameter int SPI_TMO  = 4095
)(
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [7:0]          cs_idx,
    input  logic [23:0]         tx_bytes,
    input  logic                spitxready,
    input  logic [7:0]          spirx,
    input  logic                spirxdv,
    output logic [7:0]          spitx,
    output logic                spitxdv,
    output logic [N_SPI_CS-1:0] spics_n,
    output logic                done,
    output logic [7:0]          rx_byte,
    output logic                timeout
);

    spi_state_t  st_q, st_d;
    logic [1:0]  sent_q;
    logic [23:0] tx_q;
    logic        tmo_hit;
    logic        finish;

`ifdef CMDENG_SPI_TIMEOUT_EN
    localparam int TMO_W = $clog2(SPI_TMO + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;

    assign waiting = (st_q == SPI_LD && !spitxready) || (st_q == SPI_WAIT && !spirxdv);
    assign tmo_hit = waiting && (tmo_cnt == TMO_W'(SPI_TMO - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        tmo_cnt <= '0;
        else if (waiting) tmo_cnt <= tmo_cnt + 1'b1;
        else              tmo_cnt <= '0;
    end
`else
    // Waits are unbounded; the comparison is constant-false for any legal SPI_TMO.
    assign tmo_hit = (SPI_TMO < 0);
`endif

    always_comb begin
        st_d   = st_q;
        finish = 1'b0;
        case (st_q)
            SPI_IDLE: if (start) st_d = SPI_LD;
            SPI_LD: begin
                if (tmo_hit) begin
                    st_d   = SPI_IDLE;
                    finish = 1'b1;
                end else if (spitxready) begin
                    st_d = SPI_GO;
                end
            end
            // The GO cycle gives the master one clock to drop spitxready before LD samples it again.
            SPI_GO: st_d = (sent_q == 2'd2) ? SPI_WAIT : SPI_LD;
            SPI_WAIT: begin
                if (tmo_hit || spirxdv) begin
                    st_d   = SPI_IDLE;
                    finish = 1'b1;
                end
            end
            default: st_d = SPI_IDLE;
        endcase
    end

    assign spitxdv = (st_q == SPI_GO);

    always_comb begin
        case (sent_q)
            2'd0:    spitx = tx_q[7:0];
            2'd1:    spitx = tx_q[15:8];
            default: spitx = tx_q[23:16];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= SPI_IDLE;
            sent_q  <= 2'd0;
            tx_q    <= '0;
            spics_n <= '1;
            done    <= 1'b0;
            rx_byte <= '0;
            timeout <= 1'b0;
        end else begin
            st_q <= st_d;
            done <= finish;
            if (st_q == SPI_IDLE && start) begin
                tx_q    <= tx_bytes;
                sent_q  <= 2'd0;
                spics_n <= ~(N_SPI_CS'(1) << cs_idx);
                timeout <= 1'b0;
            end
            if (st_q == SPI_GO) sent_q <= sent_q + 2'd1;
            if (finish) begin
                spics_n <= '1;
                timeout <= tmo_hit;
                rx_byte <= spirx;
            end
        end
    end

endmodule

// File: rtl/command_engine.sv
// Host command processor: byte commands in over AXI-stream, decoded actions, 32-bit response beats out.
// Define CMDENG_SPI_TIMEOUT_EN to bound the SPI waits (see cmdeng_spi_seq).
module command_engine
    import cmdeng_pkg::*;
#(
    parameter int          CMD_BYTES = 8,
    parameter int          N_SPI_CS  = 4,
    parameter int          N_REGS    = 8,
    parameter int          FIFO_W    = 32,
    parameter int          USED_W    = 11,
    parameter logic [31:0] VERSION   = 32'd5,
    parameter int          SPI_TMO   = 4095
)(
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  i_tready,
    input  logic                  i_tvalid,
    input  logic [7:0]            i_tdata,
    input  logic                  o_tready,
    output logic                  o_tvalid,
    output logic [31:0]           o_tdata,
    output logic [3:0]            o_tkeep,
    output logic                  o_tlast,
    output logic                  clkswitch,
    output logic [7:0]            spitx,
    output logic                  spitxdv,
    input  logic                  spitxready,
    input  logic [7:0]            spirx,
    input  logic                  spirxdv,
    output logic [N_SPI_CS-1:0]   spics_n,
    output logic                  fifo_rd,
    input  logic [FIFO_W-1:0]     fifo_rdata,
    input  logic [USED_W-1:0]     fifo_rdused,
    output logic [32*N_REGS-1:0]  cfg_regs
);

    localparam int CNT_W  = $clog2(CMD_BYTES);
    localparam int REG_AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q [CMD_BYTES];
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [31:0]       len_q;
    logic [31:0]       regs_q [N_REGS];
    logic [31:0]       dec_resp;
    logic [7:0]        opcode, idx;
    logic [31:0]       arg;
    logic [REG_AW-1:0] reg_sel;
    logic              reg_ok, cs_ok, rx_last;
    logic              spi_start, spi_done, spi_tmo;
    logic [7:0]        spi_rx;

    assign opcode   = cmd_q[0];
    assign idx      = cmd_q[1];
    assign arg      = {cmd_q[7], cmd_q[6], cmd_q[5], cmd_q[4]};
    assign reg_sel  = idx[REG_AW-1:0];
    assign reg_ok   = int'(idx) < N_REGS;
    assign cs_ok    = int'(idx) < N_SPI_CS;
    assign rx_last  = (byte_cnt_q == CNT_W'(CMD_BYTES - 1));
    assign i_tready = (state_q == ST_RX);

    for (genvar k = 0; k < N_REGS; k++) begin : g_cfg
        assign cfg_regs[32*k +: 32] = regs_q[k];
    end

    cmdeng_spi_seq #(
        .N_SPI_CS (N_SPI_CS),
        .SPI_TMO  (SPI_TMO)
    ) u_spi (
        .clk        (clk),
        .rstn       (rstn),
        .start      (spi_start),
        .cs_idx     (idx),
        .tx_bytes   ({cmd_q[4], cmd_q[3], cmd_q[2]}),
        .spitxready (spitxready),
        .spirx      (spirx),
        .spirxdv    (spirxdv),
        .spitx      (spitx),
        .spitxdv    (spitxdv),
        .spics_n    (spics_n),
        .done       (spi_done),
        .rx_byte    (spi_rx),
        .timeout    (spi_tmo)
    );

    always_comb begin
        state_d   = state_q;
        spi_start = 1'b0;
        case (state_q)
            ST_RX: if (i_tvalid && rx_last) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_READOUT: state_d = (arg == 32'd0) ? ST_RX : ST_RD_FETCH;
                    OP_SPI: begin
                        if (cs_ok) begin
                            state_d   = ST_SPI;
                            spi_start = 1'b1;
                        end else begin
                            state_d = ST_RESP;
                        end
                    end
                    default: state_d = ST_RESP;
                endcase
            end
            ST_RESP:     if (o_tready) state_d = ST_RX;
            ST_SPI:      if (spi_done) state_d = ST_RESP;
            ST_RD_FETCH: if (fifo_rdused != '0) state_d = ST_RD_SEND;
            ST_RD_SEND:  if (o_tready) state_d = o_tlast ? ST_RX : ST_RD_FETCH;
            default:     state_d = ST_RX;
        endcase
    end

    // Single-beat reply word; anything not recognised falls through to the error word.
    always_comb begin
        dec_resp = ERR_BASE | {24'd0, opcode};
        case (opcode)
            OP_CLKSW:   dec_resp = {31'd0, ~clkswitch};
            OP_VERSION: dec_resp = VERSION;
            OP_WRREG:   if (reg_ok) dec_resp = arg;
            OP_RDREG:   if (reg_ok) dec_resp = regs_q[reg_sel];
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_RX;
        else       state_q <= state_d;
    end

    // Command bytes carry no control meaning until DECODE, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_RX && i_tvalid) cmd_q[byte_cnt_q] <= i_tdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt_q <= '0;
            len_q      <= '0;
            clkswitch  <= 1'b0;
            fifo_rd    <= 1'b0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tkeep    <= '0;
            o_tlast    <= 1'b0;
            for (int k = 0; k < N_REGS; k++) regs_q[k] <= '0;
        end else begin
            fifo_rd <= 1'b0;
            case (state_q)
                ST_RX: begin
                    if (i_tvalid) byte_cnt_q <= rx_last ? '0 : byte_cnt_q + 1'b1;
                end
                ST_DECODE: begin
                    len_q <= arg;
                    if (opcode == OP_CLKSW) clkswitch <= ~clkswitch;
                    if (opcode == OP_WRREG && reg_ok) regs_q[reg_sel] <= arg;
                    if (state_d == ST_RESP) begin
                        o_tvalid <= 1'b1;
                        o_tdata  <= dec_resp;
                        o_tkeep  <= 4'b1111;
                        o_tlast  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (o_tready) o_tvalid <= 1'b0;
                end
                ST_SPI: begin
                    if (spi_done) begin
                        o_tvalid <= 1'b1;
                        o_tdata  <= spi_tmo ? ERR_SPI_TMO : {24'd0, spi_rx};
                        o_tkeep  <= 4'b1111;
                        o_tlast  <= 1'b1;
                    end
                end
                // Show-ahead FIFO: the head word is valid now, fifo_rd only retires it.
                ST_RD_FETCH: begin
                    if (fifo_rdused != '0) begin
                        fifo_rd  <= 1'b1;
                        o_tvalid <= 1'b1;
                        o_tdata  <= fifo_rdata[31:0];
                        o_tkeep  <= tkeep_for(len_q);
                        o_tlast  <= (len_q <= 32'd4);
                    end
                end
                ST_RD_SEND: begin
                    if (o_tready) begin
                        o_tvalid <= 1'b0;
                        len_q    <= len_q - ((len_q >= 32'd4) ? 32'd4 : len_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
